// File: rtl/pc_sequencer.sv
// Program counter with run/halt/single-step control, conditional jumps on
// ALU flags and a hardware call/return stack.
module pc_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 8,
  parameter int FLAG_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           run,
  input  logic                           hlt,
  input  logic                           step,
  input  logic                           code_edit,
  input  logic                           hlt_instr,
  input  logic                           j_en,
  input  logic [2:0]                     j_op,
  input  logic [ADDR_W-1:0]              jmp_addr,
  input  logic [FLAG_W-1:0]              flag,
  output logic [ADDR_W-1:0]              pc,
  output logic [ADDR_W-1:0]              pc_inc,
  output logic                           exec,
  output logic                           running,
  output logic [$clog2(STACK_DEPTH):0]   stack_level,
  output logic                           stack_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int LVL_W = SP_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(STACK_DEPTH);

  localparam logic [2:0] OP_JMP  = 3'b000;
  localparam logic [2:0] OP_JZ   = 3'b001;
  localparam logic [2:0] OP_JNZ  = 3'b010;
  localparam logic [2:0] OP_JC   = 3'b011;
  localparam logic [2:0] OP_JNC  = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_RET  = 3'b110;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] pop_data;
  logic [LVL_W-1:0]  lvl_dec;
  logic [SP_W-1:0]   push_idx;
  logic [SP_W-1:0]   pop_idx;
  logic              is_call;
  logic              is_ret;
  logic              fault;
  logic              commit;
  logic              push;
  logic              unused_flag;

  assign unused_flag = ^flag;

  assign pc_inc   = pc + 1'b1;
  assign exec     = (state == RUN || state == STEP) && !code_edit;
  assign running  = (state == RUN);

  assign lvl_dec  = stack_level - 1'b1;
  assign push_idx = stack_level[SP_W-1:0];
  assign pop_idx  = lvl_dec[SP_W-1:0];
  assign pop_data = stack_mem[pop_idx];

  assign is_call  = j_en && (j_op == OP_CALL);
  assign is_ret   = j_en && (j_op == OP_RET);
  assign fault    = (is_call && stack_level == FULL_LVL) ||
                    (is_ret  && stack_level == '0);

  // An in-flight instruction is dropped by hlt, HLT itself, or a stack fault.
  assign commit   = exec && !hlt && !hlt_instr && !fault;
  assign push     = commit && is_call;

  always_comb begin
    next_pc = pc_inc;
    if (j_en) begin
      unique case (j_op)
        OP_JMP:  next_pc = jmp_addr;
        OP_JZ:   next_pc = flag[0]  ? jmp_addr : pc_inc;
        OP_JNZ:  next_pc = !flag[0] ? jmp_addr : pc_inc;
        OP_JC:   next_pc = flag[1]  ? jmp_addr : pc_inc;
        OP_JNC:  next_pc = !flag[1] ? jmp_addr : pc_inc;
        OP_CALL: next_pc = jmp_addr;
        OP_RET:  next_pc = pop_data;
        default: next_pc = pc_inc;
      endcase
    end
  end

  // Stack contents need no reset; only the level decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HALT;
      pc          <= '0;
      stack_level <= '0;
      stack_err   <= 1'b0;
    end else if (code_edit || hlt) begin
      state <= HALT;
    end else begin
      unique case (state)
        HALT: begin
          if (run) begin
            state     <= RUN;
            stack_err <= 1'b0;
          end else if (step) begin
            state <= STEP;
          end
        end
        RUN, STEP: begin
          if (hlt_instr) begin
            state <= HALT;
          end else if (fault) begin
            stack_err <= 1'b1;
            state     <= HALT;
          end else begin
            pc <= next_pc;
            if (is_call) begin
              stack_level <= stack_level + 1'b1;
            end else if (is_ret) begin
              stack_level <= lvl_dec;
            end
            state <= (state == STEP) ? HALT : RUN;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: counting, jumps, call stack,
// fault handling, single-step and halt/edit interactions.
module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       hlt;
  logic       step;
  logic       code_edit;
  logic       hlt_instr;
  logic       j_en;
  logic [2:0] j_op;
  logic [7:0] jmp_addr;
  logic [7:0] flag;
  logic [7:0] pc;
  logic [7:0] pc_inc;
  logic       exec;
  logic       running;
  logic [3:0] stack_level;
  logic       stack_err;

  int assert_count = 0;
  int fail_count   = 0;

  pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(8), .FLAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .hlt(hlt), .step(step),
    .code_edit(code_edit), .hlt_instr(hlt_instr), .j_en(j_en), .j_op(j_op),
    .jmp_addr(jmp_addr), .flag(flag), .pc(pc), .pc_inc(pc_inc), .exec(exec),
    .running(running), .stack_level(stack_level), .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic h, input logic s,
                               input logic ce, input logic hi, input logic je,
                               input logic [2:0] op, input logic [7:0] ja,
                               input logic [7:0] fl);
    run = r; hlt = h; step = s; code_edit = ce; hlt_instr = hi;
    j_en = je; j_op = op; jmp_addr = ja; flag = fl;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 3'b000, 8'h00, 8'h00);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic runPulse();
    applyStimulus(1, 0, 0, 0, 0, 0, 3'b000, 8'h00, 8'h00);
    cycle();
    idle();
  endtask

  task automatic jump(input logic [2:0] op, input logic [7:0] ja, input logic [7:0] fl);
    applyStimulus(0, 0, 0, 0, 0, 1, op, ja, fl);
    cycle();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_pc", pc, 8'h00);
    checkOutput("rst_pc_inc", pc_inc, 8'h01);
    checkOutput("rst_running", running, 1'b0);
    checkOutput("rst_exec", exec, 1'b0);
    checkOutput("rst_level", stack_level, 4'd0);
    checkOutput("rst_err", stack_err, 1'b0);
    rst_n = 1'b1;

    $display("[TB] free-running count with wrap");
    runPulse();
    checkOutput("run_running", running, 1'b1);
    checkOutput("run_exec", exec, 1'b1);
    checkOutput("run_pc0", pc, 8'h00);
    for (int k = 1; k <= 300; k++) begin
      cycle();
      checkOutput("count_pc", pc, k % 256);
      checkOutput("count_running", running, 1'b1);
    end

    $display("[TB] asynchronous reset mid-run");
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midrst_pc", pc, 8'h00);
    checkOutput("midrst_running", running, 1'b0);
    cycle();
    rst_n = 1'b1;
    runPulse();
    repeat (16) cycle();
    checkOutput("reach_10", pc, 8'h10);

    $display("[TB] conditional jumps");
    jump(3'b001, 8'h40, 8'h01);
    checkOutput("jz_taken", pc, 8'h40);
    jump(3'b000, 8'h10, 8'h00);
    checkOutput("jmp", pc, 8'h10);
    jump(3'b001, 8'h40, 8'h00);
    checkOutput("jz_not_taken", pc, 8'h11);
    jump(3'b010, 8'h30, 8'h00);
    checkOutput("jnz_taken", pc, 8'h30);
    jump(3'b011, 8'h50, 8'h02);
    checkOutput("jc_taken", pc, 8'h50);
    jump(3'b100, 8'h60, 8'h02);
    checkOutput("jnc_not_taken", pc, 8'h51);
    jump(3'b111, 8'h60, 8'h00);
    checkOutput("nop_op", pc, 8'h52);

    $display("[TB] call and return");
    jump(3'b000, 8'h05, 8'h00);
    jump(3'b101, 8'h80, 8'h00);
    checkOutput("call_pc", pc, 8'h80);
    checkOutput("call_level", stack_level, 4'd1);
    jump(3'b110, 8'h00, 8'h00);
    checkOutput("ret_pc", pc, 8'h06);
    checkOutput("ret_level", stack_level, 4'd0);

    $display("[TB] stack overflow and underflow");
    for (int k = 0; k < 8; k++) begin
      jump(3'b101, 8'hA0 + 8'(k), 8'h00);
    end
    checkOutput("full_level", stack_level, 4'd8);
    checkOutput("full_pc", pc, 8'hA7);
    jump(3'b101, 8'hC0, 8'h00);
    checkOutput("ovf_err", stack_err, 1'b1);
    checkOutput("ovf_running", running, 1'b0);
    checkOutput("ovf_pc", pc, 8'hA7);
    checkOutput("ovf_level", stack_level, 4'd8);
    runPulse();
    checkOutput("resume_err", stack_err, 1'b0);
    checkOutput("resume_running", running, 1'b1);
    jump(3'b110, 8'h00, 8'h00);
    checkOutput("pop8_pc", pc, 8'hA7);
    checkOutput("pop8_level", stack_level, 4'd7);
    jump(3'b110, 8'h00, 8'h00);
    checkOutput("pop7_pc", pc, 8'hA6);
    repeat (5) jump(3'b110, 8'h00, 8'h00);
    checkOutput("pop2_pc", pc, 8'hA1);
    checkOutput("pop2_level", stack_level, 4'd1);
    jump(3'b110, 8'h00, 8'h00);
    checkOutput("pop1_pc", pc, 8'h07);
    checkOutput("pop1_level", stack_level, 4'd0);
    jump(3'b110, 8'h00, 8'h00);
    checkOutput("udf_err", stack_err, 1'b1);
    checkOutput("udf_running", running, 1'b0);
    checkOutput("udf_pc", pc, 8'h07);
    checkOutput("udf_level", stack_level, 4'd0);

    $display("[TB] halt and single-step");
    runPulse();
    jump(3'b000, 8'h20, 8'h00);
    checkOutput("goto_20", pc, 8'h20);
    applyStimulus(0, 1, 0, 0, 0, 1, 3'b000, 8'h99, 8'h00);
    cycle();
    idle();
    checkOutput("hlt_running", running, 1'b0);
    checkOutput("hlt_pc", pc, 8'h20);
    checkOutput("hlt_exec", exec, 1'b0);
    applyStimulus(0, 0, 1, 0, 0, 0, 3'b000, 8'h00, 8'h00);
    cycle();
    idle();
    checkOutput("step1_exec", exec, 1'b1);
    checkOutput("step1_running", running, 1'b0);
    checkOutput("step1_pc_before", pc, 8'h20);
    cycle();
    checkOutput("step1_pc", pc, 8'h21);
    checkOutput("step1_exec_after", exec, 1'b0);
    applyStimulus(0, 0, 1, 0, 0, 0, 3'b000, 8'h00, 8'h00);
    cycle();
    idle();
    checkOutput("step2_exec", exec, 1'b1);
    cycle();
    checkOutput("step2_pc", pc, 8'h22);
    checkOutput("step2_exec_after", exec, 1'b0);
    applyStimulus(0, 0, 1, 0, 0, 0, 3'b000, 8'h00, 8'h00);
    cycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 3'b000, 8'h00, 8'h00);
    cycle();
    idle();
    checkOutput("step_hltinstr_pc", pc, 8'h22);
    checkOutput("step_hltinstr_exec", exec, 1'b0);

    $display("[TB] hlt/run collision and code edit");
    runPulse();
    checkOutput("rerun_running", running, 1'b1);
    cycle();
    checkOutput("rerun_pc", pc, 8'h23);
    applyStimulus(1, 1, 0, 0, 0, 0, 3'b000, 8'h00, 8'h00);
    cycle();
    idle();
    checkOutput("hltrun_running", running, 1'b0);
    checkOutput("hltrun_pc", pc, 8'h23);
    applyStimulus(0, 0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h00);
    cycle();
    applyStimulus(1, 0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h00);
    cycle();
    checkOutput("edit_running", running, 1'b0);
    checkOutput("edit_pc", pc, 8'h23);
    checkOutput("edit_exec", exec, 1'b0);
    idle();
    cycle();
    checkOutput("edit_release_running", running, 1'b0);

    runPulse();
    applyStimulus(0, 0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h00);
    #1;
    checkOutput("edit_in_run_exec", exec, 1'b0);
    checkOutput("edit_in_run_running", running, 1'b1);
    cycle();
    idle();
    checkOutput("edit_in_run_halt", running, 1'b0);
    checkOutput("edit_in_run_pc", pc, 8'h23);

    $display("[TB] hlt_instr beats CALL");
    runPulse();
    applyStimulus(0, 0, 0, 0, 1, 1, 3'b101, 8'h70, 8'h00);
    cycle();
    idle();
    checkOutput("hltcall_pc", pc, 8'h23);
    checkOutput("hltcall_level", stack_level, 4'd0);
    checkOutput("hltcall_running", running, 1'b0);

    $display("[TB] reset during CALL");
    runPulse();
    jump(3'b101, 8'h70, 8'h00);
    checkOutput("call70_pc", pc, 8'h70);
    checkOutput("call70_level", stack_level, 4'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 3'b101, 8'h90, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstcall_level", stack_level, 4'd0);
    checkOutput("rstcall_pc", pc, 8'h00);
    checkOutput("rstcall_running", running, 1'b0);
    idle();
    cycle();
    rst_n = 1'b1;
    cycle();
    checkOutput("rstcall_hold_level", stack_level, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
